// File: rtl/axi_refill_arbiter.sv
// Round-robin refill arbiter for the im/dm caches: fetches one line over AXI4 INCR bursts
// into a shared buffer and hands it to the winning requester with a CDC-safe ack.
module axi_refill_arbiter #(
    parameter int CACHE_SIZE = 1024,
    parameter int MAX_BURST  = 256
) (
    input  logic                       axi_clk,
    input  logic                       i_rstn,
    input  logic                       im_rd_rq,
    input  logic                       dm_rd_rq,
    input  logic [31:0]                im_rd_addr,
    input  logic [31:0]                dm_rd_addr,
    output logic                       im_rd_valid,
    output logic                       dm_rd_valid,
    output logic [31:0]                rd_valid_addr,
    output logic [CACHE_SIZE-1:0][31:0] rd_data,
    input  logic                       im_rd_ack,
    input  logic                       dm_rd_ack,
    output logic                       m_arvalid,
    input  logic                       m_arready,
    output logic [31:0]                m_araddr,
    output logic [7:0]                 m_arlen,
    output logic [2:0]                 m_arsize,
    output logic [1:0]                 m_arburst,
    input  logic                       m_rvalid,
    output logic                       m_rready,
    input  logic [31:0]                m_rdata,
    input  logic [1:0]                 m_rresp,
    input  logic                       m_rlast,
    output logic                       rd_err,
    output logic                       rd_err_id
);

    localparam int NBURST = CACHE_SIZE / MAX_BURST;
    localparam int OFFW   = $clog2(CACHE_SIZE * 4);
    localparam int KW     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int BW     = (NBURST > 1) ? $clog2(NBURST) : 1;
    localparam int IW     = (CACHE_SIZE > 1) ? $clog2(CACHE_SIZE) : 1;
    localparam int BSH    = $clog2(MAX_BURST) + 2;
    localparam logic [31:0] BASE_MASK = ~((32'd1 << OFFW) - 32'd1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DELIVER} state_e;

    state_e                     state_q, state_d;
    logic                       pendIm_q, pendIm_d, pendDm_q, pendDm_d;
    logic [31:0]                addrIm_q, addrIm_d, addrDm_q, addrDm_d;
    logic                       lastDm_q, lastDm_d;
    logic                       grantDm_q, grantDm_d;
    logic [31:0]                base_q, base_d;
    logic [BW-1:0]              burst_q, burst_d;
    logic [KW-1:0]              beat_q, beat_d;
    logic                       err_q, err_d;
    logic                       rdErr_q, rdErr_d, rdErrId_q, rdErrId_d;
    logic [2:0]                 imAckSync_q, dmAckSync_q;
    logic [CACHE_SIZE-1:0][31:0] rdData_q;

    logic grantIm, grantDm, lastBeat, lastBurst, beatWr, errNow, imRise, dmRise;
    logic [IW-1:0] wordIdx;

    assign lastBeat  = (beat_q == KW'(MAX_BURST - 1));
    assign lastBurst = (burst_q == BW'(NBURST - 1));
    assign wordIdx   = IW'(32'(burst_q) * 32'(MAX_BURST) + 32'(beat_q));
    // Bits [1] are the synchronized ack; bit [2] is its previous value for edge detection.
    assign imRise    = imAckSync_q[1] & ~imAckSync_q[2];
    assign dmRise    = dmAckSync_q[1] & ~dmAckSync_q[2];

    always_ff @(posedge axi_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            pendIm_q    <= 1'b0;
            pendDm_q    <= 1'b0;
            addrIm_q    <= '0;
            addrDm_q    <= '0;
            lastDm_q    <= 1'b1;
            grantDm_q   <= 1'b0;
            base_q      <= '0;
            burst_q     <= '0;
            beat_q      <= '0;
            err_q       <= 1'b0;
            rdErr_q     <= 1'b0;
            rdErrId_q   <= 1'b0;
            imAckSync_q <= '0;
            dmAckSync_q <= '0;
        end else begin
            state_q     <= state_d;
            pendIm_q    <= pendIm_d;
            pendDm_q    <= pendDm_d;
            addrIm_q    <= addrIm_d;
            addrDm_q    <= addrDm_d;
            lastDm_q    <= lastDm_d;
            grantDm_q   <= grantDm_d;
            base_q      <= base_d;
            burst_q     <= burst_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
            rdErr_q     <= rdErr_d;
            rdErrId_q   <= rdErrId_d;
            imAckSync_q <= {imAckSync_q[1:0], im_rd_ack};
            dmAckSync_q <= {dmAckSync_q[1:0], dm_rd_ack};
        end
    end

    always_ff @(posedge axi_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rdData_q <= '0;
        end else if (beatWr) begin
            rdData_q[wordIdx] <= m_rdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        pendIm_d  = pendIm_q;
        pendDm_d  = pendDm_q;
        addrIm_d  = addrIm_q;
        addrDm_d  = addrDm_q;
        lastDm_d  = lastDm_q;
        grantDm_d = grantDm_q;
        base_d    = base_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        err_d     = err_q;
        rdErr_d   = 1'b0;
        rdErrId_d = rdErrId_q;
        beatWr    = 1'b0;
        errNow    = err_q;
        grantIm   = pendIm_q & (~pendDm_q | lastDm_q);
        grantDm   = pendDm_q & (~pendIm_q | ~lastDm_q);

        case (state_q)
            IDLE: begin
                if (grantIm || grantDm) begin
                    state_d   = ADDR;
                    grantDm_d = grantDm;
                    lastDm_d  = grantDm;
                    base_d    = (grantDm ? addrDm_q : addrIm_q) & BASE_MASK;
                    burst_d   = '0;
                    beat_d    = '0;
                    err_d     = 1'b0;
                    if (grantDm) pendDm_d = 1'b0;
                    else         pendIm_d = 1'b0;
                end
            end
            ADDR: begin
                if (m_arready) state_d = DATA;
            end
            DATA: begin
                if (m_rvalid) begin
                    beatWr = 1'b1;
                    // The beat counter ends the burst; rlast only feeds the error flag.
                    errNow = err_q | (m_rresp != 2'b00) | (m_rlast != lastBeat);
                    err_d  = errNow;
                    if (lastBeat) begin
                        beat_d = '0;
                        if (lastBurst) begin
                            if (errNow) begin
                                rdErr_d   = 1'b1;
                                rdErrId_d = grantDm_q;
                                state_d   = IDLE;
                            end else begin
                                state_d = DELIVER;
                            end
                        end else begin
                            burst_d = burst_q + BW'(1);
                            state_d = ADDR;
                        end
                    end else begin
                        beat_d = beat_q + KW'(1);
                    end
                end
            end
            DELIVER: begin
                if (grantDm_q ? dmRise : imRise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A new request always re-arms pending, even in the cycle its previous one is granted.
        if (im_rd_rq) begin
            pendIm_d = 1'b1;
            addrIm_d = im_rd_addr;
        end
        if (dm_rd_rq) begin
            pendDm_d = 1'b1;
            addrDm_d = dm_rd_addr;
        end
    end

    assign m_arvalid     = (state_q == ADDR);
    assign m_rready      = (state_q == DATA);
    assign m_araddr      = base_q | (32'(burst_q) << BSH);
    assign m_arlen       = 8'(MAX_BURST - 1);
    assign m_arsize      = 3'b010;
    assign m_arburst     = 2'b01;
    assign im_rd_valid   = (state_q == DELIVER) & ~grantDm_q;
    assign dm_rd_valid   = (state_q == DELIVER) & grantDm_q;
    assign rd_valid_addr = base_q;
    assign rd_data       = rdData_q;
    assign rd_err        = rdErr_q;
    assign rd_err_id     = rdErrId_q;

endmodule

// File: tb/tb_axi_refill_arbiter.sv
// Directed bench for axi_refill_arbiter with CACHE_SIZE=16, MAX_BURST=8 (two bursts per line).
module tb_axi_refill_arbiter;

    logic              axi_clk = 1'b0;
    logic              i_rstn;
    logic              im_rd_rq, dm_rd_rq;
    logic [31:0]       im_rd_addr, dm_rd_addr;
    logic              im_rd_valid, dm_rd_valid;
    logic [31:0]       rd_valid_addr;
    logic [15:0][31:0] rd_data;
    logic              im_rd_ack, dm_rd_ack;
    logic              m_arvalid, m_arready;
    logic [31:0]       m_araddr;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic [1:0]        m_arburst;
    logic              m_rvalid, m_rready;
    logic [31:0]       m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast;
    logic              rd_err, rd_err_id;

    int checks = 0;
    int failures = 0;

    axi_refill_arbiter #(.CACHE_SIZE(16), .MAX_BURST(8)) dut (
        .axi_clk(axi_clk), .i_rstn(i_rstn),
        .im_rd_rq(im_rd_rq), .dm_rd_rq(dm_rd_rq),
        .im_rd_addr(im_rd_addr), .dm_rd_addr(dm_rd_addr),
        .im_rd_valid(im_rd_valid), .dm_rd_valid(dm_rd_valid),
        .rd_valid_addr(rd_valid_addr), .rd_data(rd_data),
        .im_rd_ack(im_rd_ack), .dm_rd_ack(dm_rd_ack),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast),
        .rd_err(rd_err), .rd_err_id(rd_err_id)
    );

    always #5 axi_clk = ~axi_clk;

    // Pulses the selected requests for one cycle; called right after a negedge.
    task automatic pulse_rq(input logic im, input logic dm, input logic [31:0] imAddr, input logic [31:0] dmAddr);
        im_rd_rq = im;
        dm_rd_rq = dm;
        im_rd_addr = imAddr;
        dm_rd_addr = dmAddr;
        @(negedge axi_clk);
        im_rd_rq = 1'b0;
        dm_rd_rq = 1'b0;
    endtask

    // Acts as the AXI slave for one burst: checks the AR, then returns 8 beats of seed+b*8+k.
    task automatic serve_burst(input logic [31:0] expAddr, input int b, input int arDelay,
                               input int gap, input int errBeat, input int seed);
        int t;
        t = 0;
        while (m_arvalid !== 1'b1 && t < 100) begin
            @(negedge axi_clk);
            t++;
        end
        checks++;
        if (m_arvalid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ar_timeout burst=%0d arvalid=%b required 1", b, m_arvalid);
            return;
        end
        checks++;
        if (m_araddr !== expAddr) begin
            failures++;
            $display("[TB] FAIL araddr burst=%0d got=%h required=%h", b, m_araddr, expAddr);
        end
        checks++;
        if (m_arlen !== 8'd7 || m_arsize !== 3'b010 || m_arburst !== 2'b01) begin
            failures++;
            $display("[TB] FAIL ar_fields len=%0d size=%b burst=%b required 7/010/01", m_arlen, m_arsize, m_arburst);
        end
        for (int d = 0; d < arDelay; d++) begin
            @(negedge axi_clk);
            checks++;
            if (m_arvalid !== 1'b1 || m_araddr !== expAddr) begin
                failures++;
                $display("[TB] FAIL ar_stable arvalid=%b araddr=%h required 1/%h", m_arvalid, m_araddr, expAddr);
            end
        end
        m_arready = 1'b1;
        @(negedge axi_clk);
        m_arready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (gap != 0) begin
                m_rvalid = 1'b0;
                @(negedge axi_clk);
            end
            checks++;
            if (m_rready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL rready beat=%0d got=%b required 1", k, m_rready);
            end
            m_rvalid = 1'b1;
            m_rdata  = 32'(seed + b * 8 + k);
            m_rlast  = (k == 7);
            m_rresp  = (k == errBeat) ? 2'b10 : 2'b00;
            @(negedge axi_clk);
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rresp  = 2'b00;
    endtask

    // Serves a whole line, then checks either the delivery/ack sequence or the error pulse.
    task automatic do_refill(input logic [31:0] expBase, input logic isDm, input int arDelay,
                             input int gap, input int errBeat, input int seed);
        logic ok;
        serve_burst(expBase, 0, arDelay, gap, errBeat, seed);
        checks++;
        if (m_arvalid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL turnaround arvalid=%b required 1", m_arvalid);
        end
        serve_burst(expBase + 32'h20, 1, arDelay, gap, -1, seed);
        if (errBeat >= 0) begin
            checks++;
            if (rd_err !== 1'b1 || rd_err_id !== isDm || im_rd_valid !== 1'b0 || dm_rd_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL err_pulse err=%b id=%b valids=%b%b required 1/%b/00",
                         rd_err, rd_err_id, im_rd_valid, dm_rd_valid, isDm);
            end
            @(negedge axi_clk);
            checks++;
            if (rd_err !== 1'b0 || m_arvalid !== 1'b0 || im_rd_valid !== 1'b0 || dm_rd_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL err_after err=%b arvalid=%b valids=%b%b required 0/0/00",
                         rd_err, m_arvalid, im_rd_valid, dm_rd_valid);
            end
            return;
        end
        checks++;
        if (im_rd_valid !== !isDm || dm_rd_valid !== isDm || rd_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL valid im=%b dm=%b err=%b required im=%b dm=%b err=0",
                     im_rd_valid, dm_rd_valid, rd_err, !isDm, isDm);
        end
        checks++;
        if (rd_valid_addr !== expBase) begin
            failures++;
            $display("[TB] FAIL valid_addr got=%h required=%h", rd_valid_addr, expBase);
        end
        ok = 1'b1;
        for (int i = 0; i < 16; i++) if (rd_data[i] !== 32'(seed + i)) ok = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL line_data word0=%h word15=%h required %h/%h",
                     rd_data[0], rd_data[15], 32'(seed), 32'(seed + 15));
        end
        if (isDm) dm_rd_ack = 1'b1;
        else      im_rd_ack = 1'b1;
        repeat (2) @(negedge axi_clk);
        checks++;
        if ((isDm ? dm_rd_valid : im_rd_valid) !== 1'b1) begin
            failures++;
            $display("[TB] FAIL valid_hold got=0 required 1 two cycles after ack");
        end
        @(negedge axi_clk);
        checks++;
        if (im_rd_valid !== 1'b0 || dm_rd_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL valid_drop im=%b dm=%b required 00", im_rd_valid, dm_rd_valid);
        end
        im_rd_ack = 1'b0;
        dm_rd_ack = 1'b0;
        repeat (3) @(negedge axi_clk);
    endtask

    task automatic test_reset();
        i_rstn = 1'b0;
        repeat (3) @(negedge axi_clk);
        checks++;
        if (im_rd_valid !== 1'b0 || dm_rd_valid !== 1'b0 || m_arvalid !== 1'b0 || m_rready !== 1'b0 ||
            rd_err !== 1'b0 || rd_err_id !== 1'b0 || rd_valid_addr !== 32'h0 || rd_data[0] !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs valids=%b%b arvalid=%b rready=%b err=%b id=%b addr=%h d0=%h required all 0",
                     im_rd_valid, dm_rd_valid, m_arvalid, m_rready, rd_err, rd_err_id, rd_valid_addr, rd_data[0]);
        end
        checks++;
        if (m_arsize !== 3'b010 || m_arburst !== 2'b01) begin
            failures++;
            $display("[TB] FAIL reset_consts size=%b burst=%b required 010/01", m_arsize, m_arburst);
        end
        i_rstn = 1'b1;
        @(negedge axi_clk);
    endtask

    task automatic test_tie();
        pulse_rq(1'b1, 1'b1, 32'h0000_4040, 32'h0000_8888);
        do_refill(32'h0000_4040, 1'b0, 0, 0, -1, 32'h10);
        do_refill(32'h0000_8880, 1'b1, 0, 0, -1, 32'h20);
        pulse_rq(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0200);
        do_refill(32'h0000_0100, 1'b0, 0, 0, -1, 32'h30);
        do_refill(32'h0000_0200, 1'b1, 0, 0, -1, 32'h40);
    endtask

    task automatic test_single();
        pulse_rq(1'b1, 1'b0, 32'h0000_1234, 32'h0);
        checks++;
        if (m_arvalid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rq_latency_early arvalid=%b required 0", m_arvalid);
        end
        @(negedge axi_clk);
        checks++;
        if (m_arvalid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rq_latency arvalid=%b required 1", m_arvalid);
        end
        do_refill(32'h0000_1200, 1'b0, 0, 0, -1, 0);
    endtask

    task automatic test_mid();
        pulse_rq(1'b1, 1'b0, 32'h0000_3004, 32'h0);
        serve_burst(32'h0000_3000, 0, 0, 0, -1, 32'h50);
        pulse_rq(1'b0, 1'b1, 32'h0, 32'h0000_5000);
        pulse_rq(1'b0, 1'b1, 32'h0, 32'h0000_6000);
        serve_burst(32'h0000_3020, 1, 0, 0, -1, 32'h50);
        checks++;
        if (im_rd_valid !== 1'b1 || m_arvalid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_im_valid valid=%b arvalid=%b required 1/0", im_rd_valid, m_arvalid);
        end
        im_rd_ack = 1'b1;
        repeat (3) @(negedge axi_clk);
        checks++;
        if (im_rd_valid !== 1'b0 || m_arvalid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_idle valid=%b arvalid=%b required 0/0", im_rd_valid, m_arvalid);
        end
        im_rd_ack = 1'b0;
        @(negedge axi_clk);
        checks++;
        if (m_arvalid !== 1'b1 || m_araddr !== 32'h0000_6000) begin
            failures++;
            $display("[TB] FAIL mid_dm_ar arvalid=%b araddr=%h required 1/00006000", m_arvalid, m_araddr);
        end
        do_refill(32'h0000_6000, 1'b1, 0, 0, -1, 32'h60);
        begin
            logic sawAr;
            sawAr = 1'b0;
            repeat (10) begin
                @(negedge axi_clk);
                if (m_arvalid === 1'b1) sawAr = 1'b1;
            end
            checks++;
            if (sawAr !== 1'b0) begin
                failures++;
                $display("[TB] FAIL mid_once extra AR seen=%b required 0", sawAr);
            end
        end
    endtask

    task automatic test_error();
        pulse_rq(1'b0, 1'b1, 32'h0, 32'h0000_7010);
        do_refill(32'h0000_7000, 1'b1, 0, 0, 3, 32'h70);
    endtask

    task automatic test_backpressure();
        pulse_rq(1'b1, 1'b0, 32'h0000_9ABC, 32'h0);
        do_refill(32'h0000_9A80, 1'b0, 5, 1, -1, 32'h55);
    endtask

    task automatic test_reset_mid();
        pulse_rq(1'b1, 1'b0, 32'h0000_A000, 32'h0);
        serve_burst(32'h0000_A000, 0, 0, 0, -1, 32'h80);
        m_arready = 1'b1;
        @(negedge axi_clk);
        m_arready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_rvalid = 1'b1;
            m_rdata  = 32'(32'h88 + k);
            @(negedge axi_clk);
        end
        i_rstn = 1'b0;
        m_rvalid = 1'b0;
        #1;
        checks++;
        if (m_arvalid !== 1'b0 || m_rready !== 1'b0 || im_rd_valid !== 1'b0 || dm_rd_valid !== 1'b0 ||
            rd_err !== 1'b0 || rd_valid_addr !== 32'h0 || rd_data[0] !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_mid arvalid=%b rready=%b valids=%b%b err=%b addr=%h d0=%h required all 0",
                     m_arvalid, m_rready, im_rd_valid, dm_rd_valid, rd_err, rd_valid_addr, rd_data[0]);
        end
        repeat (2) @(negedge axi_clk);
        i_rstn = 1'b1;
        repeat (4) @(negedge axi_clk);
        checks++;
        if (im_rd_valid !== 1'b0 || rd_err !== 1'b0 || m_arvalid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_stale valid=%b err=%b arvalid=%b required 0/0/0", im_rd_valid, rd_err, m_arvalid);
        end
        pulse_rq(1'b0, 1'b1, 32'h0, 32'h0000_B05C);
        do_refill(32'h0000_B040, 1'b1, 0, 0, -1, 32'h100);
    endtask

    initial begin
        i_rstn = 1'b0;
        im_rd_rq = 1'b0;
        dm_rd_rq = 1'b0;
        im_rd_addr = '0;
        dm_rd_addr = '0;
        im_rd_ack = 1'b0;
        dm_rd_ack = 1'b0;
        m_arready = 1'b0;
        m_rvalid = 1'b0;
        m_rdata = '0;
        m_rresp = 2'b00;
        m_rlast = 1'b0;
        test_reset();
        test_tie();
        test_single();
        test_mid();
        test_error();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_refill_arbiter.md
# axi_refill_arbiter

Refill sequencer and arbiter on the `axi_clk` side of the cache subsystem. It accepts line-refill requests from the instruction cache (im) and the data cache (dm), grants them round-robin, and fetches one full `CACHE_SIZE`-word line over a shared AXI4 read channel as one or more INCR bursts. It assembles the line in a single shared buffer, then presents it to the winning requester with a valid/ack handshake. The ack crosses from `mem_clk`.

## Interface

Parameters:

- `CACHE_SIZE`, 1024: words per line. Power of 2.
- `MAX_BURST`, 256: beats per AXI burst. Power of 2, ≤256, divides `CACHE_SIZE`.

Ports:

- `axi_clk` in 1: sole clock.
- `i_rstn` in 1: reset, asynchronous, active-low.
- `im_rd_rq`, `dm_rd_rq` in 1: refill request pulse, one `axi_clk` cycle.
- `im_rd_addr`, `dm_rd_addr` in 32: miss address, sampled with the rq pulse.
- `im_rd_valid`, `dm_rd_valid` out 1: line ready for that requester.
- `rd_valid_addr` out 32: line-aligned base of the delivered line.
- `rd_data` out `CACHE_SIZE`×32: shared line buffer; word i is at byte `base+4i`.
- `im_rd_ack`, `dm_rd_ack` in 1: ack from the `mem_clk` domain; asynchronous to `axi_clk`.
- `m_arvalid` out 1, `m_arready` in 1, `m_araddr` out 32, `m_arlen` out 8: AR channel.
- `m_arsize` out 3, `m_arburst` out 2: AR channel, constants `3'b010` and `2'b01`.
- `m_rvalid` in 1, `m_rready` out 1, `m_rdata` in 32, `m_rresp` in 2, `m_rlast` in 1: R channel.
- `rd_err` out 1: one-cycle pulse when a refill is dropped.
- `rd_err_id` out 1: requester of the dropped refill; 0 = im, 1 = dm.

## Operation

- Request capture:
  - An rq pulse sets that requester's pending bit and latches its address into a per-requester register.
  - An rq while already pending overwrites the address; it does not queue a second request.
  - An rq while that requester is being served sets pending again, so it is served after the current refill.
- Line base: `addr` with its low `log2(CACHE_SIZE*4)` bits cleared.
- Arbitration happens in IDLE only:
  - If only one requester is pending, grant it.
  - If both are pending, grant the one not granted last. The last-grant pointer resets to dm, so im wins the first tie.
  - Granting clears that requester's pending bit.
- FSM states: IDLE, ADDR, DATA, DELIVER.
  - IDLE → ADDR on a grant.
  - ADDR: `m_arvalid`=1, `m_araddr`=base+b·`MAX_BURST`·4, `m_arlen`=`MAX_BURST`-1. ADDR → DATA on `m_arvalid`&`m_arready`.
  - DATA: `m_rready`=1. Each `m_rvalid` beat writes `m_rdata` into buffer word b·`MAX_BURST`+k, then increments k.
  - After beat k=`MAX_BURST`-1, go to ADDR for the next burst b+1, or leave DATA when b=`CACHE_SIZE`/`MAX_BURST`-1.
  - Leaving after the last burst: to DELIVER if the error flag is clear; otherwise pulse `rd_err`/`rd_err_id` and go to IDLE.
  - DELIVER: assert the granted `*_rd_valid` and drive `rd_valid_addr`=base. On the rising edge of the synchronized granted ack, drop valid and go to IDLE.
- Beat counter k is authoritative. `m_rlast` is checked, not used to terminate a burst.
- Error flag: set by `m_rresp`≠`2'b00` on any beat, or by `m_rlast` mismatching k=`MAX_BURST`-1. It is cleared on grant. All remaining bursts are still issued and drained.
- Ack synchronization: each ack passes through a 2-flop synchronizer, then a rising-edge detect. Ack on the non-granted requester is ignored.
- `rd_data` holds its contents until overwritten by the next refill's beats.

## Timing

- Reset values: all outputs 0 (valids, `m_arvalid`, `m_rready`, `rd_data`, `rd_valid_addr`, `rd_err`, `rd_err_id`), except `m_arsize`/`m_arburst`, which are constants. FSM → IDLE; pending bits cleared; pointer = dm.
- Reset mid-refill aborts immediately: no valid and no `rd_err` follow.
- Request latency: rq high in cycle N → pending set at edge N+1 → `m_arvalid` high in cycle N+2, provided the FSM was IDLE.
- Burst turnaround: `m_arvalid` is high in the cycle after the last beat of the previous burst.
- Valid latency: `*_rd_valid` is high in the cycle after the final beat of the line.
- Valid deassert: 3 `axi_clk` cycles after the ack rises at the synchronizer input (2 sync + 1 edge).
- System constraint: `mem_clk` period > 4 `axi_clk` periods, so valid drops before the cache re-samples it.
- `m_arvalid` is held with its address stable until `m_arready`, per AXI. Back-pressure on either channel only stretches the refill.

## Test plan

- Single refill, `CACHE_SIZE`=16, `MAX_BURST`=8: im rq with addr 0x1234 → two ARs (araddr 0x1200 then 0x1220, arlen 7). After 16 beats (data = beat index), `rd_data[i]`=i, `im_rd_valid`=1, `rd_valid_addr`=0x1200. Drive the ack → valid drops 3 cycles later.
- Simultaneous im and dm rq in the same cycle after reset → im served first, then dm (araddr from `dm_rd_addr`). A second simultaneous pair → im first again, because the pointer now points at dm.
- dm rq arrives mid im-refill → it stays pending, and its AR issues 1 cycle after im reaches IDLE. A second dm rq while pending → only the latest address is fetched, once.
- `m_rresp`=`2'b10` on beat 3 of burst 0 → burst 1 is still fetched; no valid; `rd_err`=1 for one cycle with `rd_err_id`=granted requester; FSM returns to IDLE.
- `m_arready` low for 5 cycles and `m_rvalid` gapped every other cycle → `m_araddr` stable throughout, line contents correct, valid 1 cycle after the last beat.
- `i_rstn` low during burst 1 → all outputs 0 immediately; after release, a new rq completes normally with no stale valid or error.
